// File: rtl/core_pkg.sv
// Shared core types: memory access modes (funct3 encoding) and data-memory responder states.
package core_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_acc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for loads and stores: enables, store lane data, misalignment,
// and load extract with sign/zero extension from a raw 32-bit word.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rword_i >> {addr_i, 3'b000};

  always_comb begin
    be_o       = '0;
    wlane_o    = wdata_i;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    rdata_o    = '0;
    case (mem_acc_mode_e'(mode_i))
      MEM_B: begin
        be_o    = 4'b0001 << addr_i;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_BU: begin
        be_o    = 4'b0001 << addr_i;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      MEM_H: begin
        misalign_o = addr_i[0];
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_HU: begin
        misalign_o = addr_i[0];
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane_o    = {2{wdata_i[15:0]}};
        rdata_o    = {16'h0, shifted[15:0]};
      end
      MEM_W: begin
        misalign_o = |addr_i;
        be_o       = 4'b1111;
        rdata_o    = rword_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: one request at a time, WAIT_STATES cycles of latency,
// word-organised RAM with byte lanes, registered response held until accepted.
module dmem_responder
  import core_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] LAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [2:0]    mode_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          commit;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [2:0]    acc_mode;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          misalign, illegal, out_of_range, wr_illegal, acc_err, mem_we;
  logic [31:0]   ld_data;

  // With zero wait states the access commits on the accept edge, so it must see the live inputs.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_mode  = (state_q == IDLE) ? req_mode  : mode_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign rword     = mem_q[acc_idx];

  lsu_align u_align (
    .mode_i     (acc_mode),
    .addr_i     (acc_addr[1:0]),
    .wdata_i    (acc_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wlane_o    (wlane),
    .misalign_o (misalign),
    .illegal_o  (illegal),
    .rdata_o    (ld_data)
  );

  assign out_of_range = {1'b0, acc_addr} >= ADDR_LIMIT;
  assign wr_illegal   = acc_we && ((acc_mode == MEM_BU) || (acc_mode == MEM_HU));
  assign acc_err      = misalign || illegal || out_of_range || wr_illegal;
  assign mem_we       = commit && acc_we && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      mode_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        mode_q  <= req_mode;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err || acc_we) ? '0 : ld_data;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // RAM is deliberately not reset; rst also blocks a commit landing on a reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[acc_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with a response scoreboard.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_mode;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_mode  (req_mode),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
    string       tag;
  } step_t;

  exp_t sb[$];
  int   ncmp  = 0;
  int   nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    exp_t e;
    n = 1;
    while (!rsp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(1 + WS));
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, rsp_rdata, e.rd);
      check({tag, " err"}, {31'h0, rsp_err}, {31'h0, e.err});
    end
  endtask

  task automatic send(input step_t s);
    int n;
    sb.push_back('{rd: s.erd, err: s.eerr});
    @(negedge clk);
    req_we    = s.we;
    req_addr  = s.addr;
    req_mode  = s.mode;
    req_wdata = s.wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({s.tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    // inputs are don't-care after the accept edge
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_mode  = 3'($urandom_range(7));
    req_we    = 1'($urandom_range(1));
    wait_rsp(s.tag);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " cleared"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, " idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  step_t steps[$];

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_mode  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    #12;
    check("rst req_ready", {31'h0, req_ready}, 32'h1);
    check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    steps.push_back('{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, "sw10"});
    steps.push_back('{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, "lw10"});
    steps.push_back('{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0, "lb13"});
    steps.push_back('{1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0, "lbu13"});
    steps.push_back('{1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFFDEAD, 1'b0, "lh12"});
    steps.push_back('{1'b0, 32'h10, 3'b101, 32'h0,        32'h0000BEEF, 1'b0, "lhu10"});
    steps.push_back('{1'b1, 32'h11, 3'b000, 32'hCAFE0055, 32'h0,        1'b0, "sb11"});
    steps.push_back('{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0, "lw10_b"});
    steps.push_back('{1'b1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0,        1'b0, "sh12"});
    steps.push_back('{1'b0, 32'h10, 3'b010, 32'h0,        32'h123455EF, 1'b0, "lw10_h"});
    steps.push_back('{1'b0, 32'h12, 3'b010, 32'h0,        32'h0,        1'b1, "lw12_mis"});
    steps.push_back('{1'b1, 32'h11, 3'b001, 32'hFFFFFFFF, 32'h0,        1'b1, "sh11_mis"});
    steps.push_back('{1'b1, 32'h10, 3'b100, 32'hFFFFFFFF, 32'h0,        1'b1, "sbu_we"});
    steps.push_back('{1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, 32'h0,       1'b1, "sw_oor"});
    steps.push_back('{1'b0, 32'h10, 3'b010, 32'h0,        32'h123455EF, 1'b0, "lw10_keep"});
    steps.push_back('{1'b0, 32'h400, 3'b010, 32'h0,       32'h0,        1'b1, "lw_oor"});
    steps.push_back('{1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1, "mode011"});
    steps.push_back('{1'b1, 32'h3FF, 3'b000, 32'h80,      32'h0,        1'b0, "sb_last"});
    steps.push_back('{1'b0, 32'h3FF, 3'b000, 32'h0,       32'hFFFFFF80, 1'b0, "lb_last"});
    steps.push_back('{1'b0, 32'h3FF, 3'b100, 32'h0,       32'h00000080, 1'b0, "lbu_last"});
    steps.push_back('{1'b1, 32'h20, 3'b010, 32'h11223344, 32'h0,        1'b0, "sw20"});

    foreach (steps[i]) begin
      send(steps[i]);
      consume(steps[i].tag);
    end

    // Response held off for 5 cycles while a new request waits.
    rsp_ready = 1'b0;
    send('{1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, "hold"});
    sb.push_back('{rd: 32'h11223344, err: 1'b0});
    req_we    = 1'b0;
    req_addr  = 32'h20;
    req_mode  = 3'b010;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold rdata", rsp_rdata, 32'h123455EF);
      check("hold req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold release valid", {31'h0, rsp_valid}, 32'h0);
    check("hold release ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    check("next accepted", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0;
    wait_rsp("next lw20");
    consume("next lw20");

    // Reset while a store waits: it must not land.
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_mode  = 3'b010;
    req_wdata = 32'hAAAAAAAA;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort in_wait", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort idle", {31'h0, req_ready}, 32'h1);
    check("abort no_rsp", {31'h0, rsp_valid}, 32'h0);
    send('{1'b0, 32'h20, 3'b010, 32'h0, 32'h11223344, 1'b0, "lw20_after"});
    consume("lw20_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
